// File: rtl/checkbits_pkg.sv
// Shared types and marker encodings for the checkbits bus scoreboard.
// Workload w uses run markers MARK_RUN+16w/+1 and check markers MARK_CHK+16w/+1.
package checkbits_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  localparam logic [15:0] MARK_RUN  = 16'hAB00;
  localparam logic [15:0] MARK_CHK  = 16'hAB30;
  localparam logic [15:0] WL_STRIDE = 16'd16;

  function automatic logic [15:0] run_start(input logic [1:0] wl);
    return MARK_RUN + WL_STRIDE * {14'd0, wl};
  endfunction

  function automatic logic [15:0] run_end(input logic [1:0] wl);
    return run_start(wl) + 16'd1;
  endfunction

  function automatic logic [15:0] chk_start(input logic [1:0] wl);
    return MARK_CHK + WL_STRIDE * {14'd0, wl};
  endfunction

  function automatic logic [15:0] chk_end(input logic [1:0] wl);
    return chk_start(wl) + 16'd1;
  endfunction

endpackage

// File: rtl/checkbits_gold_ram.sv
// Golden-sequence storage: one synchronous write port, one asynchronous read port.
// Contents are not reset; firmware or the bench loads them before use.
module checkbits_gold_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 192,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/checkbits_scoreboard.sv
// Monitors the firmware checkbits bus: times run phases, compares check phases
// against a per-workload golden sequence, and aborts stalled phases via a watchdog.
module checkbits_scoreboard
  import checkbits_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int NUM_WL      = 3,
  parameter int MAX_LEN     = 64,
  parameter int STRICT      = 0,
  parameter int CYC_W       = 24,
  parameter int TIMEOUT_CYC = 200000,
  localparam int IDX_W      = $clog2(MAX_LEN + 1)
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [DATA_W-1:0] checkbits_i,
  input  logic              gold_we_i,
  input  logic [1:0]        gold_wl_i,
  input  logic [IDX_W-1:0]  gold_idx_i,
  input  logic [DATA_W-1:0] gold_data_i,
  input  logic              len_we_i,
  output logic [1:0]        state_o,
  output logic [1:0]        wl_o,
  output logic [CYC_W-1:0]  run_cycles_o,
  output logic              run_valid_o,
  output logic [NUM_WL-1:0] done_o,
  output logic [NUM_WL-1:0] pass_o,
  output logic [IDX_W-1:0]  err_cnt_o,
  output logic              timeout_o
);

  localparam int DEPTH = NUM_WL * MAX_LEN;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

  function automatic logic [CYC_W-1:0] sat_cyc(input logic [CYC_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [IDX_W-1:0] sat_idx(input logic [IDX_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [IDX_W-1:0] clamp_len(input logic [IDX_W-1:0] v);
    return (int'(v) > MAX_LEN) ? IDX_W'(MAX_LEN) : v;
  endfunction

  function automatic logic [DATA_W-1:0] mk(input logic [15:0] m);
    return DATA_W'(m);
  endfunction

  state_t             state, state_n;
  logic [1:0]         wl, wl_n;
  logic [CYC_W-1:0]   cnt, cnt_n, run_cycles, run_cycles_n;
  logic               run_valid, run_valid_n;
  logic [NUM_WL-1:0]  done, done_n, pass, pass_n;
  logic [IDX_W-1:0]   idx, idx_n, err, err_n;
  logic               tmo, tmo_n;
  logic [WD_W-1:0]    wd, wd_n;
  logic [IDX_W-1:0]   len [NUM_WL];
  logic [DATA_W-1:0]  chk_p0, chk_p1, gold;
  logic [IDX_W-1:0]   rd_idx;
  logic               evt, gold_wr;
  logic [AW-1:0]      waddr, raddr;

  // Stage p0: registered bus sample; p1 holds the previous sample for change detection
  always_ff @(posedge wb_clk_i) begin
    chk_p0 <= checkbits_i;
    chk_p1 <= chk_p0;
  end

  assign evt = (chk_p0 != chk_p1);

  assign gold_wr = gold_we_i && (int'(gold_wl_i) < NUM_WL) && (int'(gold_idx_i) < MAX_LEN);
  assign waddr   = AW'(gold_wl_i) * AW'(MAX_LEN) + AW'(gold_idx_i);
  assign rd_idx  = (int'(idx) < MAX_LEN) ? idx : '0;
  assign raddr   = AW'(wl) * AW'(MAX_LEN) + AW'(rd_idx);

  checkbits_gold_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_gold (
    .clk   (wb_clk_i),
    .we    (gold_wr),
    .waddr (waddr),
    .wdata (gold_data_i),
    .raddr (raddr),
    .rdata (gold)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int w = 0; w < NUM_WL; w++) len[w] <= IDX_W'(MAX_LEN);
    end else if (len_we_i && (int'(gold_wl_i) < NUM_WL)) begin
      len[gold_wl_i] <= clamp_len(gold_idx_i);
    end
  end

  always_comb begin
    state_n      = state;
    wl_n         = wl;
    cnt_n        = cnt;
    run_cycles_n = run_cycles;
    run_valid_n  = 1'b0;
    done_n       = done;
    pass_n       = pass;
    idx_n        = idx;
    err_n        = err;
    tmo_n        = tmo;
    wd_n         = '0;
    case (state)
      ST_IDLE: begin
        for (int w = 0; w < NUM_WL; w++) begin
          if (chk_p0 == mk(run_start(2'(w)))) begin
            state_n = ST_RUN;
            wl_n    = 2'(w);
            cnt_n   = '0;
          end else if (chk_p0 == mk(chk_start(2'(w)))) begin
            state_n   = ST_CHECK;
            wl_n      = 2'(w);
            idx_n     = '0;
            err_n     = '0;
            done_n[w] = 1'b0;
            pass_n[w] = 1'b0;
          end
        end
      end
      ST_RUN: begin
        cnt_n = sat_cyc(cnt);
        if (chk_p0 == mk(run_end(wl))) begin
          run_cycles_n = cnt;
          run_valid_n  = 1'b1;
          state_n      = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (idx < len[wl]) begin
          if (STRICT != 0) begin
            if (evt) begin
              if (chk_p0 != gold) err_n = sat_idx(err);
              idx_n = idx + 1'b1;
            end
          end else if (chk_p0 == gold) begin
            idx_n = idx + 1'b1;
          end
        end else if (chk_p0 == mk(chk_end(wl))) begin
          done_n[wl] = 1'b1;
          pass_n[wl] = (err == '0);
          state_n    = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // Watchdog counts quiet cycles only while a phase is open
    if (state != ST_IDLE && !evt && state_n == state) wd_n = wd + 1'b1;
    if (state != ST_IDLE && !evt && wd == WD_W'(TIMEOUT_CYC - 1)) begin
      tmo_n   = 1'b1;
      state_n = ST_IDLE;
      wd_n    = '0;
      if (state == ST_CHECK) done_n[wl] = 1'b1;
      pass_n[wl] = 1'b0;
    end
  end

  // Stage p1: control state update
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= ST_IDLE;
      wl         <= '0;
      cnt        <= '0;
      run_cycles <= '0;
      run_valid  <= 1'b0;
      done       <= '0;
      pass       <= '0;
      idx        <= '0;
      err        <= '0;
      tmo        <= 1'b0;
      wd         <= '0;
    end else begin
      state      <= state_n;
      wl         <= wl_n;
      cnt        <= cnt_n;
      run_cycles <= run_cycles_n;
      run_valid  <= run_valid_n;
      done       <= done_n;
      pass       <= pass_n;
      idx        <= idx_n;
      err        <= err_n;
      tmo        <= tmo_n;
      wd         <= wd_n;
    end
  end

  assign state_o      = state;
  assign wl_o         = wl;
  assign run_cycles_o = run_cycles;
  assign run_valid_o  = run_valid;
  assign done_o       = done;
  assign pass_o       = pass;
  assign err_cnt_o    = err;
  assign timeout_o    = tmo;

endmodule
